// File: rtl/irq_pending_ctrl.sv
// Four-line interrupt request capture with sticky pending/overflow bits, per-line mask,
// and a valid/ready presentation of the highest-priority enabled pending line (line 3 highest).
module irq_pending_ctrl #(
    parameter bit          EDGE    = 1'b1,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               enable,
    input  logic               irq_ready,
    output logic               irq_valid,
    output logic [1:0]         irq_id,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overflow,
    input  logic               ovf_clr
);

    localparam int unsigned ID_W = 2;

    generate
        if (NUM_REQ != 4) begin : g_bad_num_req
            $error("irq_pending_ctrl: NUM_REQ must be 4");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [NUM_REQ-1:0] ev;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] sel;
    logic [NUM_REQ-1:0] ovf_set;

    // Capture event: rising edge or level, chosen at build time
    generate
        if (EDGE) begin : g_edge
            logic [NUM_REQ-1:0] req_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_d <= '0;
                end else begin
                    req_d <= req;
                end
            end
            assign ev = req & ~req_d;
        end else begin : g_level
            assign ev = req;
        end
    endgenerate

    // Acceptance clears exactly the presented line
    always_comb begin
        clr = '0;
        if (irq_valid && irq_ready) begin
            clr[irq_id] = 1'b1;
        end
    end

    assign ovf_set   = ev & pending & ~clr;
    assign irq_valid = (state == PRESENT);

    // Set dominates clear so an event arriving in the accept cycle is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= ev | (pending & ~clr);
            overflow <= ovf_set | (ovf_clr ? '0 : overflow);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            state  <= state_nxt;
            irq_id <= id_nxt;
        end
    end

    // Ascending scan: the last enabled pending line found is the highest priority
    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        sel       = pending & mask;
        case (state)
            IDLE: begin
                if (enable && (|sel)) begin
                    state_nxt = PRESENT;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel[i]) begin
                            id_nxt = ID_W'(i);
                        end
                    end
                end
            end
            PRESENT: begin
                if (irq_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: a vector table for capture/priority/stall/mask/overflow,
// plus hand sequences for async reset and level-capture mode.
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       enable;
    logic       irq_ready;
    logic       ovf_clr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overflow;

    logic [3:0] lreq;
    logic       l_valid;
    logic [1:0] l_id;
    logic [3:0] l_pending;
    logic [3:0] l_overflow;

    int checks = 0;
    int errors = 0;

    irq_pending_ctrl #(.EDGE(1'b1), .NUM_REQ(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .enable    (enable),
        .irq_ready (irq_ready),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    irq_pending_ctrl #(.EDGE(1'b0), .NUM_REQ(4)) u_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (lreq),
        .mask      (4'hF),
        .enable    (1'b1),
        .irq_ready (1'b0),
        .irq_valid (l_valid),
        .irq_id    (l_id),
        .pending   (l_pending),
        .overflow  (l_overflow),
        .ovf_clr   (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       en;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] eid;
        logic [3:0] ep;
        logic [3:0] eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = 4'hF; enable = 1'b1;
        irq_ready = 1'b1; ovf_clr = 1'b0; lreq = '0;

        //         req   mask  en    rdy   clr   ev    id    pend  ovf
        vecs.push_back('{4'h2, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h2, 4'h0}); // single event
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'h2, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 4'h0}); // priority
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'h5, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0}); // stall
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 4'h0});
        vecs.push_back('{4'h8, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h9, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h9, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h8, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'h8, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h8, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h8, 4'h0}); // mask
        vecs.push_back('{4'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h8, 4'h0});
        vecs.push_back('{4'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h8, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'h8, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h4, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0}); // enable
        vecs.push_back('{4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
        vecs.push_back('{4'h4, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0}); // overflow
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h4, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h4});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h4});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h4, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 4'h4});
        vecs.push_back('{4'h4, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h4, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0}); // accept collision
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
        vecs.push_back('{4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});

        // Reset values while held in reset
        #12;
        chk("rst_valid", 4'(irq_valid), 4'h0);
        chk("rst_id", 4'(irq_id), 4'h0);
        chk("rst_pending", pending, 4'h0);
        chk("rst_overflow", overflow, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Level capture: a held request sets overflow after the first cycle
        lreq = 4'h2;
        cyc();
        chk("lvl_pending1", l_pending, 4'h2);
        chk("lvl_ovf1", l_overflow, 4'h0);
        chk("lvl_valid1", 4'(l_valid), 4'h0);
        @(negedge clk);
        cyc();
        chk("lvl_ovf2", l_overflow, 4'h2);
        chk("lvl_valid2", 4'(l_valid), 4'h1);
        chk("lvl_id2", 4'(l_id), 4'h1);
        @(negedge clk);
        lreq = 4'h0;
        cyc();

        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req; mask = vecs[i].mask; enable = vecs[i].en;
            irq_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
            cyc();
            chk($sformatf("v%0d_valid", i), 4'(irq_valid), 4'(vecs[i].ev));
            chk($sformatf("v%0d_pending", i), pending, vecs[i].ep);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].eo);
            if (vecs[i].ev) chk($sformatf("v%0d_id", i), 4'(irq_id), 4'(vecs[i].eid));
        end

        // Reset mid-PRESENT with overflow set: everything drops asynchronously
        @(negedge clk);
        req = 4'h1; irq_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        req = 4'h0;
        @(negedge clk);
        req = 4'h1;
        cyc();
        chk("pre_rst_valid", 4'(irq_valid), 4'h1);
        chk("pre_rst_ovf", overflow, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 4'(irq_valid), 4'h0);
        chk("mid_rst_id", 4'(irq_id), 4'h0);
        chk("mid_rst_pending", pending, 4'h0);
        chk("mid_rst_overflow", overflow, 4'h0);

        // req held high through reset release is captured as an edge
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_pending", pending, 4'h1);
        chk("post_rst_valid", 4'(irq_valid), 4'h0);
        @(negedge clk);
        cyc();
        chk("post_rst_present", 4'(irq_valid), 4'h1);
        chk("post_rst_id", 4'(irq_id), 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
